pipe_buffer: RTL

Parametrised elastic pipeline buffer, the next generation of the fixed IF/ID latch. It holds up to DEPTH in-order entries of DATA_W bits between two pipeline stages using a valid/ready handshake instead of a plain disable. It supports a one-cycle flush (kill) that empties all entries and presents a NOP pattern downstream. It is intended for IF/ID, and later ID/EX, where a stall must not lose the instruction already in flight.

---
 rtl/pipe_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_buffer.sv
// ---------------------------------------------------------------------------
// pipe_buffer
//
// Elastic in-order buffer placed between two pipeline stages (IF/ID today,
// ID/EX later). It holds up to DEPTH entries so that a downstream stall does
// not lose an instruction that is already in flight. A one-cycle kill empties
// the buffer, and a NOP pattern is then presented downstream.
//
// Parameters:
//   DATA_W    entry width, e.g. {NPC, Instruction}
//   DEPTH     number of entries, 2..16, need not be a power of two
//   NOP_VALUE value driven on out_data whenever the buffer is empty
//   CNT_W     width of the count output
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      asynchronous, active-low; clears pointers and count at once
//   in_valid   upstream presents an entry
//   in_ready   buffer can accept an entry this cycle
//   in_data    upstream entry
//   kill       synchronous flush of all entries (wins over push/pop)
//   out_valid  head holds a valid entry
//   out_ready  downstream consumes the head this cycle
//   out_data   head entry, or NOP_VALUE when empty
//   count      number of entries currently held
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high and kill is low. A producer holding valid keeps its data stable
// until it sees ready. in_ready is derived from registered state only, so
// there is no combinational path from out_ready to in_ready. A slot freed by
// a pop becomes available on the following cycle, not the current one.
// ---------------------------------------------------------------------------
module pipe_buffer #(
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  // DEPTH is at least 2 when legal, so PTR_W is at least 1.
  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16) begin : g_depth_check
    $error("pipe_buffer: DEPTH %0d is outside the legal range 2..16", DEPTH);
  end

  // Storage is never cleared: only the pointers and count are reset, and an
  // empty buffer masks the head with NOP_VALUE.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths never
  // index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;

  // Kill suppresses both transfers; the flush below then clears everything.
  assign push = in_valid  & in_ready  & ~kill;
  assign pop  = out_valid & out_ready & ~kill;

  // No same-cycle bypass: an entry pushed while empty shows up after the edge.
  assign out_data = out_valid ? mem[rd_ptr] : NOP_VALUE;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (kill) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
